// File: rtl/spi_regfile_peripheral_if.sv
// Pin-side and core-side signals of the SPI register-file peripheral.
// The peripheral uses the slave modport; a controller/testbench uses master.
interface spi_regfile_peripheral_if #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 8
);
  logic                       nCS;
  logic                       SCLK;
  logic                       COPI;
  logic                       CIPO;
  logic                       cipo_oe;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       frame_err;
  logic [7:0]                 err_count;

  modport slave (
    input  nCS, SCLK, COPI,
    output CIPO, cipo_oe, regs_out, wr_strobe, wr_addr, frame_err, err_count
  );

  modport master (
    output nCS, SCLK, COPI,
    input  CIPO, cipo_oe, regs_out, wr_strobe, wr_addr, frame_err, err_count
  );
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing NUM_REGS registers with read-back, write strobe
// and framing-error detection. Pins are oversampled in the clk domain.
module spi_regfile_peripheral #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic                     clk,
  input logic                     rst,
  spi_regfile_peripheral_if.slave bus
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int ADDR_P1 = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_CMD    = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0]  CNT_FRAME  = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_L = ADDR_P1'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_OVER} state_t;
  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_ncs_sync, r_sclk_sync, r_copi_sync;
  logic                   r_ncs_d, r_sclk_d;
  logic                   w_ncs, w_sclk, w_copi;
  logic                   w_sclk_rise, w_sclk_fall, w_ncs_rise;

  logic [CNT_W-1:0]           r_cnt;
  logic [FRAME_W-1:0]         r_shift;
  logic [DATA_W-1:0]          r_rd_shift, w_rd_data;
  logic                       r_cipo, r_cipo_oe;
  logic                       r_wr_strobe, r_frame_err;
  logic [ADDR_W-1:0]          r_wr_addr;
  logic [7:0]                 r_err_count;
  logic [NUM_REGS*DATA_W-1:0] w_regs_flat;
  logic                       w_load_rd, w_do_wr, w_do_err;

  logic              w_cmd_rw, w_fr_rw;
  logic [ADDR_W-1:0] w_cmd_addr, w_fr_addr;
  logic [DATA_W-1:0] w_fr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ncs_sync  <= '1;
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_d     <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], bus.nCS};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], bus.COPI};
      r_ncs_d     <= w_ncs;
      r_sclk_d    <= w_sclk;
    end
  end

  assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d & ~w_ncs;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ncs_rise  = w_ncs & ~r_ncs_d;

  // Command fields are taken from the low bits right after the address completes;
  // frame fields are taken from the full shift register at commit time.
  assign w_cmd_rw   = r_shift[ADDR_W];
  assign w_cmd_addr = r_shift[ADDR_W-1:0];
  assign w_fr_rw    = r_shift[FRAME_W-1];
  assign w_fr_addr  = r_shift[DATA_W +: ADDR_W];
  assign w_fr_data  = r_shift[DATA_W-1:0];

  assign w_do_wr  = w_ncs_rise && (r_cnt == CNT_FRAME) && w_fr_rw &&
                    ({1'b0, w_fr_addr} < NUM_REGS_L);
  assign w_do_err = w_ncs_rise && (r_cnt != CNT_FRAME) && (r_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load_rd    = 1'b0;
    case (r_state)
      S_IDLE: if (!w_ncs) w_state_next = S_CMD;
      S_CMD: begin
        if (w_ncs) w_state_next = S_IDLE;
        else if (r_cnt == CNT_CMD) begin
          w_state_next = S_DATA;
          w_load_rd    = 1'b1;
        end
      end
      S_DATA: begin
        if (w_ncs) w_state_next = S_IDLE;
        else if (r_cnt > CNT_FRAME) w_state_next = S_OVER;
      end
      S_OVER: if (w_ncs) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Write frames and out-of-range reads load zero, so CIPO stays low for them.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!w_cmd_rw && (w_cmd_addr == ADDR_W'(i))) w_rd_data = w_regs_flat[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rd_shift <= '0;
      r_cipo     <= 1'b0;
      r_cipo_oe  <= 1'b0;
    end else begin
      r_cipo_oe <= ~w_ncs;
      if (w_ncs) begin
        r_cnt  <= '0;
        r_cipo <= 1'b0;
      end else begin
        if (w_sclk_rise) begin
          if (r_cnt < CNT_FRAME) begin
            r_shift <= {r_shift[FRAME_W-2:0], w_copi};
            r_cnt   <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= CNT_SAT;
          end
        end
        if (w_load_rd) begin
          r_rd_shift <= w_rd_data;
        end else if (w_sclk_fall && (r_state == S_DATA || r_state == S_OVER)) begin
          r_cipo     <= r_rd_shift[DATA_W-1];
          r_rd_shift <= r_rd_shift << 1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] r_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_reg <= '0;
        else if (w_do_wr && (w_fr_addr == ADDR_W'(gi))) r_reg <= w_fr_data;
      end
      assign w_regs_flat[gi*DATA_W +: DATA_W] = r_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_wr_strobe <= w_do_wr;
      r_frame_err <= w_do_err;
      if (w_do_wr) r_wr_addr <= w_fr_addr;
      if (w_do_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign bus.CIPO      = r_cipo;
  assign bus.cipo_oe   = r_cipo_oe;
  assign bus.regs_out  = w_regs_flat;
  assign bus.wr_strobe = r_wr_strobe;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.frame_err = r_frame_err;
  assign bus.err_count = r_err_count;
endmodule

// File: doc/spi_regfile_peripheral.md
# spi_regfile_peripheral

Parametrised SPI mode-0 peripheral exposing a bank of `NUM_REGS` control registers to an external SPI controller, with full read-back over CIPO. It is the next-generation configuration port for the project's PWM/output-enable logic: register width, address width and register count are generics, and it adds framing-error detection and a write-strobe output. It sits directly behind the chip pins (nCS, SCLK, COPI, CIPO) and drives flattened register contents into the core.

## Interface
- `DATA_W`, default 8: width of each register and of the data field.
- `ADDR_W`, default 7: width of the address field.
- `NUM_REGS`, default 8: number of implemented registers, at addresses 0..NUM_REGS-1; legal range 1..2^ADDR_W.
- `SYNC_STAGES`, default 2: synchroniser depth on nCS, SCLK and COPI; minimum 2.
- `clk` input 1: system clock. This is the block's only clock.
- `rst` input 1: reset, asynchronous and active-high.
- `nCS` input 1: chip select, active low, asynchronous to `clk`.
- `SCLK` input 1: SPI clock, asynchronous to `clk`.
- `COPI` input 1: controller-out serial data.
- `CIPO` output 1: peripheral-out serial data.
- `cipo_oe` output 1: pad enable for CIPO; high while synchronised nCS is low.
- `regs_out` output NUM_REGS*DATA_W: register contents; register i occupies bits [i*DATA_W +: DATA_W].
- `wr_strobe` output 1: one-cycle pulse when a register is written.
- `wr_addr` output ADDR_W: address of the last write; valid while `wr_strobe` is high.
- `frame_err` output 1: one-cycle pulse when a frame is closed with the wrong bit count.
- `err_count` output 8: saturating count of framing errors.

## Operation

**Frame format**
- FRAME_W = 1 + ADDR_W + DATA_W bits, sent MSB first.
- First bit is R/W (1 = write, 0 = read), followed by the address, then the data.

**Input sampling**
- All three pins pass through SYNC_STAGES flops. nCS synchronisers reset to 1; SCLK and COPI synchronisers reset to 0.
- Edges are detected by comparing the final synchroniser flop with one further delayed copy.
- COPI is sampled on a synchronised SCLK rising edge, and only while synchronised nCS is low.

**Bit counter and states**
- The bit counter saturates at FRAME_W+1. Bits received after FRAME_W are discarded, and the shift register is not modified by them.
- IDLE: nCS high. The counter is held at 0.
- IDLE -> CMD: nCS falls.
- CMD -> DATA: the counter reaches 1+ADDR_W.
  - For a read, the read-out shift register loads regs[addr] at this point.
  - If addr >= NUM_REGS, it loads 0 instead.
- DATA -> OVER: the counter exceeds FRAME_W.
- Any state -> IDLE: nCS rises, which triggers the commit.

**Read output**
- CIPO outputs bit DATA_W-1 of the read-out register on the first synchronised SCLK falling edge in DATA. It shifts left on each subsequent falling edge.
- CIPO is 0 in IDLE, in CMD, during a write frame, and after all data bits have been shifted out.
- Reads never modify registers.

**Commit on synchronised nCS rising edge**
- Count == FRAME_W, write, addr < NUM_REGS:
  - regs[addr] <= data;
  - `wr_strobe` pulses high for one cycle;
  - `wr_addr` <= addr.
- Count == FRAME_W, write, addr >= NUM_REGS: no register changes, no strobe, no error.
- Count == FRAME_W, read: no action.
- Count != FRAME_W and count != 0: `frame_err` pulses high for one cycle, `err_count` increments (saturating at 255), and nothing is written.
- Count == 0 (nCS toggled with no clocks): no action.

**Reset**
- Reset values: every register 0, `CIPO` 0, `cipo_oe` 0, `wr_strobe` 0, `wr_addr` 0, `frame_err` 0, `err_count` 0, counter 0, state IDLE.
- Asserting `rst` mid-frame discards the transaction immediately.
- After `rst` is released with nCS still low, the first synchronised nCS level is low. That partial frame is received, but its length will normally be wrong, so it is committed as a framing error, never as a write.

## Timing
- Pin-to-detect latency is SYNC_STAGES clk cycles. The action resulting from a detected edge is registered on the following clk edge.
- `regs_out`, `wr_strobe`, `wr_addr`, `frame_err` and `err_count` update on the (SYNC_STAGES+1)th rising clk edge after nCS rises at the pin.
- CIPO changes SYNC_STAGES+1 clk cycles after the SCLK falling edge at the pin.
- Supported SCLK: the high and low phases are each at least SYNC_STAGES+2 clk periods.
- The gap between frames (nCS high) is at least SYNC_STAGES+2 clk periods.
- Because the commit occurs after nCS rises, a back-to-back read of a just-written register returns the new value.
- All outputs are registered. There is no combinational path from pin to output.

## Test plan
- Write: frame 0x83A5 (write, addr 3, data 0xA5) -> `regs_out[31:24]` = 0xA5, `wr_strobe` pulses once with `wr_addr` = 3, all other registers stay 0.
- Read-back: after the write above, send frame 0x0300 -> CIPO bits 1,0,1,0,0,1,0,1 on data-phase edges, `cipo_oe` high for the whole frame, no strobe, registers unchanged. Read of addr 0x10 -> all-zero data.
- Out-of-range write: frame 0x9055 (addr 0x10 >= 8) -> no register change, no `wr_strobe`, no `frame_err`.
- Framing errors:
  - 12-bit frame -> `frame_err` pulses, `err_count` = 1, no write.
  - 20-bit frame carrying 0x83A5 followed by 4 extra bits -> `err_count` = 2, no write.
  - 300 short frames -> `err_count` holds 255.
- Reset mid-frame: assert `rst` after 9 bits of 0x8211 -> all outputs 0 immediately. Completing the frame after release produces a framing error, and regs[2] stays 0.
- Parameter sweep: repeat the write and read-back scenarios with DATA_W=16, ADDR_W=4, NUM_REGS=16, SYNC_STAGES=3, writing 0xBEEF to addr 15 -> exact read-back, and all pin-to-output latencies match the Timing section.
